// File: rtl/intr_ctrl_pkg.sv
// rtl/intr_ctrl_pkg.sv - shared types and constants for the interrupt controller.
package intr_package;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_REL = 2'd2
  } intr_state_t;

  localparam int INTR_N_SRC_DEFAULT = 4;

  localparam int INTR_SRC_UART_RX = 0;
  localparam int INTR_SRC_TIMER   = 1;

endpackage

// File: rtl/intr_prio_enc.sv
// rtl/intr_prio_enc.sv - combinational lowest-index-wins priority encoder.
module intr_prio_enc #(
  parameter  int N_SRC = 4,
  localparam int ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] vector,
  output logic             any_pend,
  output logic [ID_W-1:0]  sel_id
);

  always_comb begin
    any_pend = |vector;
    sel_id   = '0;
    // Scan downwards so the lowest set index is the last to assign.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (vector[i]) sel_id = ID_W'(i);
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - edge-capturing interrupt controller with four-phase ack handshake.
// Optional per-source eligibility mask port when INTR_CTRL_MASK_EN is defined.
module intr_ctrl
  import intr_package::*;
#(
  parameter  int N_SRC = INTR_N_SRC_DEFAULT,
  localparam int ID_W  = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_req,
`ifdef INTR_CTRL_MASK_EN
  input  logic [N_SRC-1:0] src_mask,
`endif
  input  logic             intr_en,
  input  logic             ack,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] pending
);

  intr_state_t      state;
  logic [N_SRC-1:0] src_d;
  logic             armed;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] eligible;
  logic             any_pend;
  logic [ID_W-1:0]  sel_id;

  // History is cleared by reset, so the first post-reset cycle is ignored to
  // keep a line held high through reset from looking like a new edge.
  assign rise = src_req & ~src_d & {N_SRC{armed}};

`ifdef INTR_CTRL_MASK_EN
  assign eligible = pending & src_mask;
`else
  assign eligible = pending;
`endif

  always_comb begin
    clr = '0;
    if (state == REQ && ack) clr[irq_id] = 1'b1;
  end

  intr_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
    .vector   (eligible),
    .any_pend (any_pend),
    .sel_id   (sel_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      src_d   <= '0;
      armed   <= 1'b0;
      pending <= '0;
      irq     <= 1'b0;
      irq_id  <= '0;
    end else begin
      src_d   <= src_req;
      armed   <= 1'b1;
      // A new rise wins over the ack clear of the same bit.
      pending <= (pending & ~clr) | rise;
      case (state)
        IDLE: begin
          if (any_pend && intr_en && !ack) begin
            irq_id <= sel_id;
            irq    <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (ack) begin
            irq   <= 1'b0;
            state <= WAIT_REL;
          end else if (!intr_en) begin
            irq   <= 1'b0;
            state <= IDLE;
          end
        end
        WAIT_REL: begin
          irq <= 1'b0;
          if (!ack) state <= IDLE;
        end
        default: begin
          irq   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - directed table-driven bench for intr_ctrl (covers INTR_CTRL_MASK_EN when defined).
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] src_req;
`ifdef INTR_CTRL_MASK_EN
  logic [3:0] src_mask;
`endif
  logic       intr_en;
  logic       ack;
  logic       irq;
  logic [1:0] irq_id;
  logic [3:0] pending;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] src;
    logic       en;
    logic       ak;
    logic       e_irq;
    logic [1:0] e_id;
    logic [3:0] e_pend;
  } vec_t;

  vec_t vecs[$];

  intr_ctrl #(.N_SRC(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .src_req  (src_req),
`ifdef INTR_CTRL_MASK_EN
    .src_mask (src_mask),
`endif
    .intr_en  (intr_en),
    .ack      (ack),
    .irq      (irq),
    .irq_id   (irq_id),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] s, input logic e, input logic a,
                     input logic ei, input logic [1:0] eid, input logic [3:0] ep);
    vec_t v;
    v.src = s; v.en = e; v.ak = a; v.e_irq = ei; v.e_id = eid; v.e_pend = ep;
    vecs.push_back(v);
  endtask

  initial begin
    // single event on source 2
    add(4'b0000, 1, 0, 0, 0, 4'b0000);
    add(4'b0100, 1, 0, 0, 0, 4'b0100);
    add(4'b0000, 1, 0, 1, 2, 4'b0100);
    add(4'b0000, 1, 0, 1, 2, 4'b0100);
    add(4'b0000, 1, 1, 0, 0, 4'b0000);
    add(4'b0000, 1, 1, 0, 0, 4'b0000);
    add(4'b0000, 1, 0, 0, 0, 4'b0000);
    add(4'b0000, 1, 0, 0, 0, 4'b0000);
    // sources 3 and 1 together: 1 first, then 3
    add(4'b1010, 1, 0, 0, 0, 4'b1010);
    add(4'b1010, 1, 0, 1, 1, 4'b1010);
    add(4'b1010, 1, 1, 0, 0, 4'b1000);
    add(4'b1010, 1, 0, 0, 0, 4'b1000);
    add(4'b1010, 1, 0, 1, 3, 4'b1000);
    add(4'b1010, 1, 1, 0, 0, 4'b0000);
    add(4'b1010, 1, 0, 0, 0, 4'b0000);
    add(4'b0000, 1, 0, 0, 0, 4'b0000);
    // ack held in IDLE blocks the request and clears nothing
    add(4'b0001, 1, 1, 0, 0, 4'b0001);
    add(4'b0001, 1, 1, 0, 0, 4'b0001);
    add(4'b0001, 1, 0, 1, 0, 4'b0001);
    add(4'b0001, 1, 1, 0, 0, 4'b0000);
    add(4'b0000, 1, 0, 0, 0, 4'b0000);
    add(4'b0000, 1, 0, 0, 0, 4'b0000);
    // two rises of source 2 while pending merge into one event
    add(4'b0100, 0, 0, 0, 0, 4'b0100);
    add(4'b0000, 0, 0, 0, 0, 4'b0100);
    add(4'b0100, 0, 0, 0, 0, 4'b0100);
    add(4'b0000, 0, 0, 0, 0, 4'b0100);
    add(4'b0000, 1, 0, 1, 2, 4'b0100);
    add(4'b0000, 1, 1, 0, 0, 4'b0000);
    add(4'b0000, 1, 0, 0, 0, 4'b0000);
    add(4'b0000, 1, 0, 0, 0, 4'b0000);

    reset = 1'b1; src_req = '0; intr_en = 1'b1; ack = 1'b0;
`ifdef INTR_CTRL_MASK_EN
    src_mask = 4'b1111;
`endif
    step(); step();
    chk("reset_irq", 32'(irq), 32'd0);
    chk("reset_id", 32'(irq_id), 32'd0);
    chk("reset_pending", 32'(pending), 32'd0);
    reset = 1'b0;
    step();

    foreach (vecs[i]) begin
      src_req = vecs[i].src; intr_en = vecs[i].en; ack = vecs[i].ak;
      step();
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].e_irq));
      chk($sformatf("vec%0d_pending", i), 32'(pending), 32'(vecs[i].e_pend));
      if (vecs[i].e_irq) chk($sformatf("vec%0d_id", i), 32'(irq_id), 32'(vecs[i].e_id));
    end

    // enable gating and withdrawal
    intr_en = 1'b0; src_req = 4'b0001; step();
    chk("gate_pending", 32'(pending), 32'b0001);
    src_req = 4'b0000;
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("gate_irq_low%0d", k), 32'(irq), 32'd0);
    end
    intr_en = 1'b1; step(); step();
    chk("gate_irq_high", 32'(irq), 32'd1);
    chk("gate_id", 32'(irq_id), 32'd0);
    intr_en = 1'b0; step();
    chk("withdraw_irq", 32'(irq), 32'd0);
    chk("withdraw_pending", 32'(pending), 32'b0001);
    intr_en = 1'b1; step();
    chk("rearm_irq", 32'(irq), 32'd1);
    ack = 1'b1; step(); ack = 1'b0; step(); step();
    chk("gate_done_pending", 32'(pending), 32'd0);

    // rise lands on the same edge as the ack clear of that bit
    src_req = 4'b0010; step(); step();
    chk("coll_irq", 32'(irq), 32'd1);
    chk("coll_id", 32'(irq_id), 32'd1);
    src_req = 4'b0000; step();
    src_req = 4'b0010; ack = 1'b1; step();
    chk("coll_irq_low", 32'(irq), 32'd0);
    chk("coll_pending_kept", 32'(pending), 32'b0010);
    ack = 1'b0; step(); step();
    chk("coll_second_irq", 32'(irq), 32'd1);
    chk("coll_second_id", 32'(irq_id), 32'd1);
    ack = 1'b1; step(); ack = 1'b0; step(); step();
    chk("coll_done_pending", 32'(pending), 32'd0);
    src_req = 4'b0000; step();

    // reset in the middle of a handshake, sources held high across it
    src_req = 4'b0011; step(); step();
    chk("mid_irq", 32'(irq), 32'd1);
    chk("mid_pending", 32'(pending), 32'b0011);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_id", 32'(irq_id), 32'd0);
    step(); step(); step();
    chk("held_pending", 32'(pending), 32'd0);
    chk("held_irq", 32'(irq), 32'd0);
    src_req = 4'b0000; step();

`ifdef INTR_CTRL_MASK_EN
    src_mask = 4'b1110; src_req = 4'b0001; step();
    chk("mask_pending", 32'(pending), 32'b0001);
    step();
    chk("mask_irq_low", 32'(irq), 32'd0);
    src_mask = 4'b1111; step(); step();
    chk("unmask_irq", 32'(irq), 32'd1);
    chk("unmask_id", 32'(irq_id), 32'd0);
    src_mask = 4'b1110; step();
    chk("mask_in_req_irq", 32'(irq), 32'd1);
    ack = 1'b1; step(); ack = 1'b0; step(); step();
    chk("mask_done_pending", 32'(pending), 32'd0);
    src_mask = 4'b1111; src_req = 4'b0000; step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt controller directly upstream of the CPU interrupt interface.
- Captures rising edges from N peripheral request lines (UART RX, timer, ...) into pending bits and picks the highest-priority pending source.
- Raises irq with a stable source id to the CPU, then retires the request using the CPU's ack level. The CPU drives ack through w_intr into intr[0], so ack is a register level, not a pulse.
- Also consumes the CPU's intr_en status (sr.intr_en).

Parameters:
- N_SRC, 4, number of interrupt sources (2..16).
- ID_W, $clog2(N_SRC), width of source id (localparam, derived).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- src_req  input  N_SRC  level request lines from peripherals; a 0->1 transition is one interrupt event
- intr_en  input  1  CPU global interrupt enable (sr.intr_en)
- ack  input  1  CPU acknowledge level (intr[0])
- irq  output  1  interrupt request to CPU
- irq_id  output  ID_W  source index of the current request; valid while irq=1
- pending  output  N_SRC  pending event bits, for debug/status read

Behaviour:
- Reset: irq=0, irq_id=0, pending=0, edge-history register=0, state=IDLE. Reset aborts any handshake in progress; a source held high through reset does not create an event.
- Edge detect: src_d <= src_req every cycle. rise = src_req & ~src_d. A rise at cycle t sets pending[i] at t+1.
- Priority: lowest index wins. Combinational encoder over pending gives sel_id and any_pend.
- FSM states:
  - IDLE: if any_pend && intr_en && !ack, latch irq_id <= sel_id and go to REQ. irq rises the next cycle, so minimum latency is src rise -> irq = 2 cycles.
  - REQ: irq=1, irq_id held stable even if a higher-priority bit becomes pending.
    - ack=1: clear pending[irq_id], go to WAIT_REL, irq=0 the next cycle.
    - intr_en=0 before ack: go to IDLE, irq=0, pending kept (request withdrawn, re-raised later).
  - WAIT_REL: irq=0. Go to IDLE when ack=0. This is a four-phase handshake; no new request is issued while ack is held high.
- Simultaneous set and clear of the same pending bit in one cycle: set wins, so the bit stays 1 and the new event is not lost.
- Repeated rises of a source while its bit is already pending merge into one event. There is no counting.
- ack=1 while in IDLE: ignored; no pending bit changes.
- N_SRC not a power of two: the encoder only considers indices < N_SRC.

Optional Feature:
- Macro: INTR_CTRL_MASK_EN.
- Defined:
  - Adds input port src_mask [N_SRC] (1 = enabled).
  - Masked sources still latch into pending but are excluded from the priority encoder and any_pend.
  - Unmasking a pending source makes it eligible the next cycle.
  - Masking the source currently in REQ does not withdraw irq.
- Undefined: the port is absent and all sources are always eligible.

Decomposition:
- Shared package intr_package:
  - typedef enum logic [1:0] intr_state_t {IDLE, REQ, WAIT_REL}
  - localparam INTR_N_SRC_DEFAULT = 4
  - Source index constants: INTR_SRC_UART_RX = 0, INTR_SRC_TIMER = 1
- Sub-module intr_prio_enc:
  - Parameterized by N_SRC.
  - Inputs: vector.
  - Outputs: any_pend and sel_id (lowest set index).
  - Purely combinational.

Test Plan:
- Single event: reset, intr_en=1; pulse src_req[2] at cycle 5 -> pending=4'b0100 at cycle 6, irq=1 with irq_id=2 at cycle 7. ack=1 at cycle 10 -> irq=0 and pending=0 at cycle 11; ack=0 at cycle 12 -> state IDLE at cycle 13.
- Priority: src_req[3] and src_req[1] rise in the same cycle -> first irq_id=1. After ack and release, the second irq has irq_id=3; pending is 0 at the end.
- Enable gating: intr_en=0, src_req[0] rises -> pending[0]=1, irq stays 0 for 20 cycles. Raise intr_en=1 -> irq=1 with irq_id=0 two cycles later. Dropping intr_en during REQ -> irq=0, pending[0] still 1.
- Set/clear collision: src_req[1] falls and rises again so its rise lands in the same cycle as ack clears pending[1] -> pending[1] stays 1, and a second irq with id 1 follows after ack release.
- Reset mid-handshake: in REQ with pending=4'b0011, assert reset for 1 cycle -> irq=0, pending=0, irq_id=0. A src_req held high across reset causes no event.
- With INTR_CTRL_MASK_EN: src_mask=4'b1110, src_req[0] rises -> pending[0]=1, irq=0. Set src_mask=4'b1111 -> irq=1 with irq_id=0 the cycle after the next.
